rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named CLK and RESET.
REQ-002 Parameter: RR_EN, default 1, round-robin arbitration when 1, fixed priority to requester 0 when 0.
REQ-003 Port CLK  in  1  rising-edge clock for all state.
REQ-004 Port RESET  in  1  async active-high reset.
REQ-005 Port req0_valid / req1_valid  in  1 each  writeback request from ALU pipe / LSU-MDU.
REQ-006 Port req0_addr / req1_addr  in  5 each  destination register.
REQ-007 Port req0_data / req1_data  in  32 each  writeback data.
REQ-008 Port req0_ready / req1_ready  out  1 each  request accepted this cycle.
REQ-009 Port iss_valid  in  1  issue stage announces a new in-flight destination.
REQ-010 Port iss_rd  in  5  destination being issued.
REQ-011 Port iss_ready  out  1  issue may proceed.
REQ-012 Port rs1 / rs2  in  5 each  source operands being queried.
REQ-013 Port rs1_pending / rs2_pending  out  1 each  source has an outstanding write.
REQ-014 Port WE3  out  1  register-file write enable.
REQ-015 Port A3  out  5  register-file write address.
REQ-016 Port WD3  out  32  register-file write data.
REQ-017 Port err_wb  out  1  sticky flag: a writeback arrived with no pending issue.

Function
REQ-018 A transfer occurs on a rising edge where reqN_valid and reqN_ready are both 1; at most one ready is high per cycle, and ready is high only for a valid requester.
REQ-019 Requesters hold valid, addr and data stable until accepted; the block never drops a valid request.
REQ-020 Arbitration with RR_EN=1: a single valid requester is granted; when both are valid, the requester not granted in the last transfer wins; the last-grant pointer updates only on a transfer.
REQ-021 Arbitration with RR_EN=0: requester 0 always wins a conflict.
REQ-022 Output stage: a transfer at edge N drives WE3/A3/WD3 registered for exactly cycle N+1, so the register file commits on the falling edge inside that cycle.
REQ-023 Write to x0: the transfer is accepted and the arbitration pointer updates, but WE3 stays 0 in cycle N+1.
REQ-024 Scoreboard: 32 pending bits; bit 0 is constantly 0.
REQ-025 iss_ready = !pending[iss_rd] (a WAW stall); issue to x0 is always ready and sets nothing.
REQ-026 pending[iss_rd] is set at the edge where iss_valid && iss_ready.
REQ-027 pending[A3] is cleared at the rising edge ending a WE3=1 cycle.
REQ-028 A set and a clear of different registers on the same edge both take effect.
REQ-029 rsK_pending = pending[rsK], combinational; it reads 0 for x0.
REQ-030 err_wb is set at a transfer whose addr is nonzero and whose pending bit is 0; it is cleared only by RESET.

Reset
REQ-031 RESET asserted at any time, including mid-transfer, asynchronously forces: WE3=0, A3=0, WD3=0, all pending=0, pointer=requester 0, err_wb=0.
REQ-032 While RESET is high, req0_ready=req1_ready=0 and iss_ready=0; a transfer already latched into the output stage is discarded.

Structure
REQ-033 Package rf_ctrl_pkg SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and a requester-index typedef (REQ_ALU=0, REQ_LSU=1).
REQ-034 The scoreboard (pending bits, set/clear, query and iss_ready logic) SHALL be the sub-module rf_scoreboard; arbitration and the output stage stay in the top level.

Verification
REQ-035 Both requesters valid for four cycles with RR_EN=1 (req0 to x5=0x11, req1 to x6=0x22, both pre-issued): grants alternate 0,1,0,1 after reset, and WE3 pulses four cycles with A3=5,6,5,6.
REQ-036 With RR_EN=0, the same stimulus: req0 is granted every cycle while valid, and req1 waits until req0_valid drops.
REQ-037 Issue x7, query rs1=7 -> rs1_pending=1; req1 writes x7=0xDEADBEEF -> WE3=1, A3=7 next cycle, and rs1_pending=0 one edge later; re-issue x7 while pending -> iss_ready=0.
REQ-038 req0 writes x0=0xFFFFFFFF -> req0_ready=1, WE3 stays 0, err_wb stays 0.
REQ-039 A write to x9 with no prior issue -> err_wb=1 and stays 1 until RESET.
REQ-040 Issue x3, then assert RESET on a falling edge during the WE3 cycle of the x3 write -> WE3, pending and err_wb go to 0 immediately, and after release iss_ready=1 for x3.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared widths and requester identifiers for the register-file writeback path.
package rf_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_idx_e;

    function automatic req_idx_e other_req(input req_idx_e r);
        return (r == REQ_ALU) ? REQ_LSU : REQ_ALU;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  wb_pending,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr
);

    logic [NUM_REGS-1:0] pending;
    logic                set_en;

    // pending[0] is held at 0, so x0 always reads as free and issue to x0 never stalls.
    assign iss_ready   = !rst && !pending[iss_rd];
    assign set_en      = iss_valid && iss_ready && (iss_rd != '0);
    assign rs1_pending = pending[rs1];
    assign rs2_pending = pending[rs2];
    assign wb_pending  = pending[wb_addr];

    // Clear is applied before set so both land when they target different registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (clr_en) pending[clr_addr] <= 1'b0;
            if (set_en) pending[iss_rd]   <= 1'b1;
            pending[0] <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter feeding a single register-file write port,
// with a pending-write scoreboard for issue WAW stalls and operand queries.
module rf_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter bit RR_EN = 1'b1
)
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req0_valid,
    input  logic [REG_ADDR_W-1:0] req0_addr,
    input  logic [XLEN-1:0]       req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [REG_ADDR_W-1:0] req1_addr,
    input  logic [XLEN-1:0]       req1_data,
    output logic                  req1_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    output logic                  WE3,
    output logic [REG_ADDR_W-1:0] A3,
    output logic [XLEN-1:0]       WD3,
    output logic                  err_wb
);

    // Handshake: a request moves on a rising edge where valid && ready; the
    // requester holds valid/addr/data stable until then, ready never depends on
    // anything but the valids, the priority pointer and RESET.
    req_idx_e              prio;
    logic                  grant0;
    logic                  grant1;
    logic                  xfer;
    req_idx_e              win_idx;
    logic [REG_ADDR_W-1:0] win_addr;
    logic [XLEN-1:0]       win_data;
    logic                  win_pending;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && (!req1_valid || !RR_EN || prio == REQ_ALU)) grant0 = 1'b1;
        else if (req1_valid)                                          grant1 = 1'b1;
    end

    assign req0_ready = grant0 && !RESET;
    assign req1_ready = grant1 && !RESET;
    assign xfer       = req0_ready || req1_ready;
    assign win_idx    = req1_ready ? REQ_LSU : REQ_ALU;
    assign win_addr   = req1_ready ? req1_addr : req0_addr;
    assign win_data   = req1_ready ? req1_data : req0_data;

    // prio names the requester that wins the next conflict.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prio <= REQ_ALU;
        end else if (xfer && RR_EN) begin
            prio <= other_req(win_idx);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WE3    <= 1'b0;
            A3     <= '0;
            WD3    <= '0;
            err_wb <= 1'b0;
        end else begin
            WE3 <= xfer && (win_addr != '0);
            if (xfer) begin
                A3  <= win_addr;
                WD3 <= win_data;
            end
            if (xfer && (win_addr != '0) && !win_pending) err_wb <= 1'b1;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk         (CLK),
        .rst         (RESET),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .iss_ready   (iss_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .wb_addr     (win_addr),
        .wb_pending  (win_pending),
        .clr_en      (WE3),
        .clr_addr    (A3)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, iss_valid;
    logic [4:0]  req0_addr, req1_addr, iss_rd, rs1, rs2;
    logic [31:0] req0_data, req1_data;

    logic        rr_r0, rr_r1, rr_iss, rr_p1, rr_p2, rr_we, rr_err;
    logic [4:0]  rr_a3;
    logic [31:0] rr_wd;
    logic        fp_r0, fp_r1, fp_iss, fp_p1, fp_p2, fp_we, fp_err;
    logic [4:0]  fp_a3;
    logic [31:0] fp_wd;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.RR_EN(1'b1)) dut_rr (
        .CLK(clk), .RESET(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rr_r0),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rr_r1),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(rr_iss),
        .rs1(rs1), .rs2(rs2), .rs1_pending(rr_p1), .rs2_pending(rr_p2),
        .WE3(rr_we), .A3(rr_a3), .WD3(rr_wd), .err_wb(rr_err)
    );

    rf_wb_arbiter #(.RR_EN(1'b0)) dut_fp (
        .CLK(clk), .RESET(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(fp_r0),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(fp_r1),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(fp_iss),
        .rs1(rs1), .rs2(rs2), .rs1_pending(fp_p1), .rs2_pending(fp_p2),
        .WE3(fp_we), .A3(fp_a3), .WD3(fp_wd), .err_wb(fp_err)
    );

    typedef struct {
        logic        v0, v1;
        logic        r0, r1, we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        fr0, fr1, fwe;
        logic [4:0]  fa3;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else passes++;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; iss_valid = 0;
        req0_addr = 0; req1_addr = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
        req0_data = 0; req1_data = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Reference model state for the randomized phase (round-robin instance).
    bit          m_pend[32];
    int          m_prio;
    bit          m_we;
    logic [4:0]  m_a;
    logic [31:0] m_d;
    bit          m_err;

    task automatic random_phase(input int n);
        bit e_r0, e_r1, e_iss, f_r0, f_r1, x, new_err;
        logic [4:0]  xa;
        logic [31:0] xd;
        foreach (m_pend[k]) m_pend[k] = 0;
        m_prio = 0; m_we = 0; m_a = 0; m_d = 0; m_err = 0;
        for (int i = 0; i < n; i++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1; req0_addr = 5'($urandom_range(0, 7)); req0_data = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1; req1_addr = 5'($urandom_range(0, 7)); req1_data = $urandom;
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = 5'($urandom_range(0, 7));
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 7));
            @(negedge clk);
            e_r0  = req0_valid && (!req1_valid || m_prio == 0);
            e_r1  = req1_valid && (!req0_valid || m_prio == 1);
            e_iss = (iss_rd == 0) || !m_pend[iss_rd];
            f_r0  = req0_valid;
            f_r1  = req1_valid && !req0_valid;
            chk("rnd_req0_ready", 32'(rr_r0), 32'(e_r0));
            chk("rnd_req1_ready", 32'(rr_r1), 32'(e_r1));
            chk("rnd_fp_req0_ready", 32'(fp_r0), 32'(f_r0));
            chk("rnd_fp_req1_ready", 32'(fp_r1), 32'(f_r1));
            chk("rnd_iss_ready", 32'(rr_iss), 32'(e_iss));
            chk("rnd_rs1_pending", 32'(rr_p1), 32'(m_pend[rs1]));
            chk("rnd_rs2_pending", 32'(rr_p2), 32'(m_pend[rs2]));
            chk("rnd_we3", 32'(rr_we), 32'(m_we));
            if (m_we) begin
                chk("rnd_a3", 32'(rr_a3), 32'(m_a));
                chk("rnd_wd3", rr_wd, m_d);
            end
            chk("rnd_err_wb", 32'(rr_err), 32'(m_err));
            // Advance the model across the coming rising edge.
            x  = e_r0 || e_r1;
            xa = e_r1 ? req1_addr : req0_addr;
            xd = e_r1 ? req1_data : req0_data;
            new_err = m_err || (x && xa != 0 && !m_pend[xa]);
            if (m_we) m_pend[m_a] = 0;
            if (iss_valid && e_iss && iss_rd != 0) m_pend[iss_rd] = 1;
            m_err = new_err;
            m_we  = x && (xa != 0);
            if (x) begin
                m_a = xa; m_d = xd;
                m_prio = e_r1 ? 0 : 1;
            end
            next_cycle();
            if (e_r0) req0_valid = 0;
            if (e_r1) req1_valid = 0;
        end
    endtask

    initial begin
        // REQ-035/036 table: req0 -> x5=0x11, req1 -> x6=0x22.
        vecs[0] = '{v0:1, v1:1, r0:1, r1:0, we:0, a3:0, wd:0,     fr0:1, fr1:0, fwe:0, fa3:0};
        vecs[1] = '{v0:1, v1:1, r0:0, r1:1, we:1, a3:5, wd:'h11, fr0:1, fr1:0, fwe:1, fa3:5};
        vecs[2] = '{v0:1, v1:1, r0:1, r1:0, we:1, a3:6, wd:'h22, fr0:1, fr1:0, fwe:1, fa3:5};
        vecs[3] = '{v0:1, v1:1, r0:0, r1:1, we:1, a3:5, wd:'h11, fr0:1, fr1:0, fwe:1, fa3:5};
        vecs[4] = '{v0:0, v1:1, r0:0, r1:1, we:1, a3:6, wd:'h22, fr0:0, fr1:1, fwe:1, fa3:5};
        vecs[5] = '{v0:0, v1:0, r0:0, r1:0, we:1, a3:6, wd:'h22, fr0:0, fr1:0, fwe:1, fa3:6};
        vecs[6] = '{v0:0, v1:0, r0:0, r1:0, we:0, a3:0, wd:0,     fr0:0, fr1:0, fwe:0, fa3:0};

        // Reset state, with requests and issue asserted during reset.
        idle_inputs();
        rst = 1;
        req0_valid = 1; req1_valid = 1; iss_valid = 1; iss_rd = 4; rs1 = 4; rs2 = 5;
        #2;
        chk("rst_req0_ready", 32'(rr_r0), 0);
        chk("rst_req1_ready", 32'(rr_r1), 0);
        chk("rst_iss_ready", 32'(rr_iss), 0);
        chk("rst_we3", 32'(rr_we), 0);
        chk("rst_a3", 32'(rr_a3), 0);
        chk("rst_wd3", rr_wd, 0);
        chk("rst_err", 32'(rr_err), 0);
        chk("rst_pend", 32'({rr_p1, rr_p2}), 0);
        chk("rst_fp_all", 32'({fp_r0, fp_r1, fp_iss, fp_p1, fp_p2, fp_we, fp_err}), 0);
        chk("rst_fp_out", fp_wd | 32'(fp_a3), 0);
        do_reset();

        // Pre-issue x5 and x6, then run the arbitration table.
        iss_valid = 1; iss_rd = 5; next_cycle();
        iss_rd = 6;                next_cycle();
        iss_valid = 0;
        req0_addr = 5; req0_data = 'h11; req1_addr = 6; req1_data = 'h22;
        for (int i = 0; i < 7; i++) begin
            req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
            @(negedge clk);
            chk($sformatf("vec%0d_rr_r0", i), 32'(rr_r0), 32'(vecs[i].r0));
            chk($sformatf("vec%0d_rr_r1", i), 32'(rr_r1), 32'(vecs[i].r1));
            chk($sformatf("vec%0d_rr_we", i), 32'(rr_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_rr_a3", i), 32'(rr_a3), 32'(vecs[i].a3));
                chk($sformatf("vec%0d_rr_wd", i), rr_wd, vecs[i].wd);
            end
            chk($sformatf("vec%0d_fp_r0", i), 32'(fp_r0), 32'(vecs[i].fr0));
            chk($sformatf("vec%0d_fp_r1", i), 32'(fp_r1), 32'(vecs[i].fr1));
            chk($sformatf("vec%0d_fp_we", i), 32'(fp_we), 32'(vecs[i].fwe));
            if (vecs[i].fwe) chk($sformatf("vec%0d_fp_a3", i), 32'(fp_a3), 32'(vecs[i].fa3));
            next_cycle();
        end
        do_reset();

        // Issue x7, query, write back via req1, re-issue while pending.
        iss_valid = 1; iss_rd = 7; rs1 = 7;
        @(negedge clk);
        chk("x7_iss_ready", 32'(rr_iss), 1);
        chk("x7_pend_before", 32'(rr_p1), 0);
        next_cycle();
        iss_valid = 0;
        req1_valid = 1; req1_addr = 7; req1_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("x7_pend_issued", 32'(rr_p1), 1);
        chk("x7_req1_ready", 32'(rr_r1), 1);
        next_cycle();
        req1_valid = 0; iss_valid = 1; iss_rd = 7;
        @(negedge clk);
        chk("x7_we3", 32'(rr_we), 1);
        chk("x7_a3", 32'(rr_a3), 7);
        chk("x7_wd3", rr_wd, 32'hDEADBEEF);
        chk("x7_pend_during_we", 32'(rr_p1), 1);
        chk("x7_reissue_stall", 32'(rr_iss), 0);
        next_cycle();
        iss_valid = 0;
        @(negedge clk);
        chk("x7_pend_cleared", 32'(rr_p1), 0);
        chk("x7_we3_off", 32'(rr_we), 0);
        chk("x7_err", 32'(rr_err), 0);
        next_cycle();

        // Write to x0: accepted, no register write, no error.
        req0_valid = 1; req0_addr = 0; req0_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("x0_req0_ready", 32'(rr_r0), 1);
        next_cycle();
        req0_valid = 0;
        @(negedge clk);
        chk("x0_we3", 32'(rr_we), 0);
        chk("x0_err", 32'(rr_err), 0);
        next_cycle();

        // Unissued write to x9 sets the sticky error.
        req0_valid = 1; req0_addr = 9; req0_data = 32'h99;
        next_cycle();
        req0_valid = 0;
        @(negedge clk);
        chk("x9_err", 32'(rr_err), 1);
        chk("x9_we3", 32'(rr_we), 1);
        chk("x9_a3", 32'(rr_a3), 9);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("x9_err_sticky%0d", i), 32'(rr_err), 1);
        end
        next_cycle();

        // Reset on the falling edge inside the x3 WE3 cycle.
        iss_valid = 1; iss_rd = 3;
        @(negedge clk);
        chk("x3_iss_ready", 32'(rr_iss), 1);
        next_cycle();
        iss_valid = 0; req1_valid = 1; req1_addr = 3; req1_data = 32'h33;
        next_cycle();
        req1_valid = 0; rs1 = 3;
        @(negedge clk);
        chk("x3_we3", 32'(rr_we), 1);
        chk("x3_pend", 32'(rr_p1), 1);
        rst = 1; req0_valid = 1; req0_addr = 4; iss_valid = 1; iss_rd = 3;
        #1;
        chk("x3_rst_we3", 32'(rr_we), 0);
        chk("x3_rst_a3", 32'(rr_a3), 0);
        chk("x3_rst_wd3", rr_wd, 0);
        chk("x3_rst_pend", 32'(rr_p1), 0);
        chk("x3_rst_err", 32'(rr_err), 0);
        chk("x3_rst_req0_ready", 32'(rr_r0), 0);
        chk("x3_rst_iss_ready", 32'(rr_iss), 0);
        next_cycle();
        rst = 0; req0_valid = 0; iss_valid = 0;
        #1;
        chk("x3_post_iss_ready", 32'(rr_iss), 1);
        chk("x3_post_we3", 32'(rr_we), 0);
        do_reset();

        random_phase(400);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
